fb_write_scheduler: RTL and testbench

Owns the framebuffer write port and decides when the game's pixel function may repaint the 320x200 framebuffer. Each vertical blank it rasters every framebuffer coordinate to the game pixel source and forwards the returned bit to the RAM write port, so the display never reads a half-drawn frame. After every MOVE_DIV completed sweeps it pulses next_move to advance the game. It also services one-sweep clear requests, which blank the whole framebuffer.

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_raster_counter.sv | 51 +++++
 rtl/fb_write_scheduler.sv | 145 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants for the display, game and write-scheduler blocks.
package fb_pkg;
  localparam int FB_W_DEFAULT = 320;
  localparam int FB_H_DEFAULT = 200;
  localparam int X_W = 9;
  localparam int Y_W = 8;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order (x fastest) coordinate counter over an FB_W x FB_H grid.
module fb_raster_counter
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEFAULT,
  parameter int FB_H = FB_H_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           step,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  localparam logic [X_W-1:0] X_LAST = X_W'(FB_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);
endmodule

// File: rtl/fb_write_scheduler.sv
// Repaints the framebuffer once per vertical blank from the game pixel source,
// with optional clear sweeps and a sweep-divided next_move pulse.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int FB_W     = FB_W_DEFAULT,
  parameter int FB_H     = FB_H_DEFAULT,
  parameter int MOVE_DIV = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           vblank,
  input  logic           clear_req,
  output logic [X_W-1:0] src_x,
  output logic [Y_W-1:0] src_y,
  output logic           src_valid,
  input  logic           src_pixel,
  output logic           wr_en,
  output logic [X_W-1:0] wr_x,
  output logic [Y_W-1:0] wr_y,
  output logic           wr_data,
  output logic           next_move,
  output logic           busy,
  output logic           overrun,
  output logic [7:0]     frame_cnt
);
  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);

  fb_state_e      state_q, state_d;
  logic           vblank_d_q;
  logic           clear_pending_q, clear_pending_d;
  logic           clear_active_q, clear_active_d;
  logic [7:0]     div_cnt_q, div_cnt_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           next_move_q, next_move_d;
  logic           overrun_q, overrun_d;
  logic           wr_en_q, wr_en_d;
  logic [X_W-1:0] wr_x_q, wr_x_d;
  logic [Y_W-1:0] wr_y_q, wr_y_d;
  logic           wr_data_q, wr_data_d;

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           clast;
  logic           start;

  assign start = (state_q == WAIT) && vblank && !vblank_d_q && enable;

  fb_raster_counter #(.FB_W(FB_W), .FB_H(FB_H)) u_raster (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .step (src_valid),
    .x    (cx),
    .y    (cy),
    .last (clast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (start) state_d = SWEEP;
      SWEEP:   if (!vblank) state_d = WAIT;
               else if (clast) state_d = DONE;
      DONE:    state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // A sweep cycle with vblank low is dropped outright: no source, no write.
  always_comb begin
    src_valid = (state_q == SWEEP) && vblank;
    busy      = (state_q != WAIT);
    src_x     = src_valid ? cx : '0;
    src_y     = src_valid ? cy : '0;
  end

  always_comb begin
    clear_pending_d = start ? 1'b0 : (clear_pending_q | clear_req);
    clear_active_d  = clear_active_q;
    if (start) clear_active_d = clear_pending_q | clear_req;
    else if (state_q == DONE) clear_active_d = 1'b0;

    overrun_d   = overrun_q | ((state_q == SWEEP) && !vblank);
    frame_cnt_d = frame_cnt_q;
    div_cnt_d   = div_cnt_q;
    next_move_d = 1'b0;
    if (state_q == DONE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d   = '0;
        next_move_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end

    wr_en_d   = src_valid;
    wr_x_d    = src_valid ? cx : wr_x_q;
    wr_y_d    = src_valid ? cy : wr_y_q;
    wr_data_d = src_valid ? (src_pixel & ~clear_active_q) : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_d_q      <= 1'b0;
      clear_pending_q <= 1'b0;
      clear_active_q  <= 1'b0;
      div_cnt_q       <= '0;
      frame_cnt_q     <= '0;
      next_move_q     <= 1'b0;
      overrun_q       <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_x_q          <= '0;
      wr_y_q          <= '0;
      wr_data_q       <= 1'b0;
    end else begin
      vblank_d_q      <= vblank;
      clear_pending_q <= clear_pending_d;
      clear_active_q  <= clear_active_d;
      div_cnt_q       <= div_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      next_move_q     <= next_move_d;
      overrun_q       <= overrun_d;
      wr_en_q         <= wr_en_d;
      wr_x_q          <= wr_x_d;
      wr_y_q          <= wr_y_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_x      = wr_x_q;
  assign wr_y      = wr_y_q;
  assign wr_data   = wr_data_q;
  assign next_move = next_move_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler on a 4x3 framebuffer with a write scoreboard.
module tb_fb_write_scheduler;
  localparam int W = 4;
  localparam int H = 3;
  localparam int DIV = 2;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic       d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n, enable, vblank, clear_req, src_pixel;
  logic [8:0] src_x, wr_x;
  logic [7:0] src_y, wr_y, frame_cnt;
  logic       src_valid, wr_en, wr_data, next_move, busy, overrun;

  int  checks = 0, failures = 0;
  int  wr_cnt = 0, busy_cnt = 0, nm_cnt = 0, sv_cnt = 0;
  int  pix_mode = 0;
  wr_t exp_q[$];
  logic       prev_sv = 1'b0, prev_nm = 1'b0;
  logic [8:0] prev_x = '0;
  logic [7:0] prev_y = '0;

  always #5 clk = ~clk;

  assign src_pixel = (pix_mode == 0) ? src_x[0] : (pix_mode == 1);

  fb_write_scheduler #(.FB_W(W), .FB_H(H), .MOVE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vblank(vblank), .clear_req(clear_req),
    .src_x(src_x), .src_y(src_y), .src_valid(src_valid), .src_pixel(src_pixel),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .next_move(next_move), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard and activity counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      check("wr_follows_src", {prev_sv, prev_x, prev_y}, {1'b1, wr_x, wr_y});
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_xyd", {wr_x, wr_y, wr_data}, {e.x, e.y, e.d});
      end
    end
    if (busy) busy_cnt++;
    if (src_valid) sv_cnt++;
    if (next_move) begin
      nm_cnt++;
      if (prev_nm) check("next_move_width", 32'd2, 32'd1);
    end
    prev_nm = next_move;
    prev_sv = src_valid;
    prev_x  = src_x;
    prev_y  = src_y;
  end

  task automatic push_writes(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.x = 9'(i % W);
      e.y = 8'(i / W);
      e.d = clr ? 1'b0 : ((pix_mode == 0) ? e.x[0] : 1'b1);
      exp_q.push_back(e);
    end
  endtask

  // One full sweep; optionally pulses clear_req at SWEEP cycle clr_at.
  task automatic run_sweep(input logic exp_clr, input int clr_at);
    int w0, b0, t;
    w0 = wr_cnt;
    b0 = busy_cnt;
    push_writes(W * H, exp_clr);
    vblank = 1'b1;
    tick();
    t = 0;
    while (busy && t < 100) begin
      clear_req = (t == clr_at);
      tick();
      t++;
    end
    clear_req = 1'b0;
    check("sweep_timeout", (t < 100), 1);
    tick(2);
    vblank = 1'b0;
    tick(2);
    check("sweep_writes", wr_cnt - w0, W * H);
    check("sweep_busy", busy_cnt - b0, W * H + 1);
    check("sweep_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w0, nm0;
    rst_n = 1'b0; enable = 1'b0; vblank = 1'b0; clear_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();
    check("reset_outputs",
          {src_x, src_y, src_valid, wr_en, wr_x, wr_y, wr_data, next_move, busy, overrun, frame_cnt},
          '0);
    enable = 1'b1;
    tick(20);
    check("idle_writes", wr_cnt, 0);
    check("idle_src_valid", sv_cnt, 0);
    check("idle_next_move", nm_cnt, 0);

    pix_mode = 0;
    run_sweep(1'b0, -1);
    check("frame_cnt_1", frame_cnt, 1);
    check("next_move_after_1", nm_cnt, 0);
    run_sweep(1'b0, -1);
    check("next_move_after_2", nm_cnt, 1);
    run_sweep(1'b0, -1);
    check("next_move_after_3", nm_cnt, 1);
    run_sweep(1'b0, -1);
    check("next_move_after_4", nm_cnt, 2);
    check("frame_cnt_4", frame_cnt, 4);

    // Clear requested in WAIT, then one mid-sweep that lands on the following sweep.
    pix_mode = 1;
    clear_req = 1'b1; tick(); clear_req = 1'b0; tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0; tick();
    run_sweep(1'b1, -1);
    run_sweep(1'b0, 4);
    run_sweep(1'b1, -1);
    run_sweep(1'b0, -1);
    check("frame_cnt_8", frame_cnt, 8);
    check("overrun_still_0", overrun, 0);

    // Overrun: vblank drops after 5 sweep cycles.
    w0 = wr_cnt;
    nm0 = nm_cnt;
    push_writes(5, 1'b0);
    vblank = 1'b1;
    tick();
    tick(5);
    vblank = 1'b0;
    tick(3);
    check("overrun_writes", wr_cnt - w0, 5);
    check("overrun_set", overrun, 1);
    check("overrun_frame_cnt", frame_cnt, 8);
    check("overrun_no_move", nm_cnt - nm0, 0);
    check("overrun_state_wait", busy, 0);
    check("overrun_queue_empty", exp_q.size(), 0);
    run_sweep(1'b0, -1);
    check("overrun_sticky", overrun, 1);
    check("frame_cnt_9", frame_cnt, 9);

    // Disabled rise is ignored, even after enable returns while vblank stays high.
    w0 = wr_cnt;
    enable = 1'b0;
    vblank = 1'b1;
    tick(5);
    enable = 1'b1;
    tick(10);
    check("disabled_writes", wr_cnt - w0, 0);
    check("disabled_busy", busy, 0);
    vblank = 1'b0;
    tick(2);

    // Reset in the middle of a sweep.
    push_writes(W * H, 1'b0);
    vblank = 1'b1;
    tick();
    tick(6);
    check("pre_reset_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("reset_wr_en_async", wr_en, 0);
    exp_q.delete();
    tick();
    vblank = 1'b0;
    rst_n = 1'b1;
    tick(2);
    check("post_reset_state", {busy, src_valid}, 0);
    check("post_reset_overrun", overrun, 0);
    check("post_reset_frame_cnt", frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
